bsg_cache_dma_to_mem: RTL
=========================

Name: bsg_cache_dma_to_mem

Overview:
- Sits directly downstream of bsg_cache's DMA interface, in place of the nonsynth DMA model, and bridges to a simple word-wide memory port.
- Accepts one DMA packet at a time. A read (fill) issues block_size_in_words_p pipelined word reads and streams the responses back to the cache.
- A write (evict) consumes block_size_in_words_p words from the cache and issues a memory write for each word whose mask bit is set.
- Memory responses cannot be backpressured, so read issue is credit-limited against a local response FIFO.

Parameters:
- addr_width_p, 32, byte address width of the DMA packet.
- data_width_p, 32, word width of data and memory.
- block_size_in_words_p, 8, words per DMA transaction. Power of two, ≥2.
- fifo_els_p, 2, read-response buffer depth and maximum reads in flight. ≥1.
- mem_addr_width_p, addr_width_p-`BSG_SAFE_CLOG2(data_width_p/8), word address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- dma_pkt_i  in  1+block_size_in_words_p+addr_width_p  layout {write_not_read, mask, addr}.
- dma_pkt_v_i  in  1  packet valid.
- dma_pkt_yumi_o  out  1  packet consumed.
- dma_data_o  out  data_width_p  fill data to the cache.
- dma_data_v_o  out  1  fill data valid.
- dma_data_ready_i  in  1  cache ready for fill data.
- dma_data_i  in  data_width_p  evict data from the cache.
- dma_data_v_i  in  1  evict data valid.
- dma_data_yumi_o  out  1  evict word consumed.
- mem_v_o  out  1  memory request valid.
- mem_w_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  mem_addr_width_p  word address.
- mem_data_o  out  data_width_p  write data.
- mem_yumi_i  in  1  memory accepts the request this cycle. May depend combinationally on mem_v_o.
- mem_data_i  in  data_width_p  read response data.
- mem_v_i  in  1  read response valid. Responses arrive in order, ≥1 cycle after acceptance, and cannot be stalled.

Behaviour:
- States are IDLE, READ and WRITE.
- Reset values: state=IDLE, all counters=0, FIFO empty. dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o and mem_v_o are all 0. Data/address outputs are don't-care when their valid is low.
- IDLE: dma_pkt_yumi_o = dma_pkt_v_i.
  - On accept, latch mask and base = word address of addr, with the low log2(block_size_in_words_p) bits cleared. Any unaligned byte address is silently aligned.
  - Next state is READ or WRITE according to write_not_read. No packet is accepted outside IDLE.
- READ:
  - mem_v_o=1, mem_w_o=0 and mem_addr_o=base+issue_cnt while issue_cnt<block_size_in_words_p and (outstanding+fifo_count)<fifo_els_p.
  - On mem_yumi_i: issue_cnt++ and outstanding++.
  - On mem_v_i: push to the FIFO and outstanding--. Push and accept in the same cycle net to zero change in outstanding.
  - dma_data_v_o = FIFO not empty and dma_data_o = FIFO head. Dequeue on dma_data_v_o & dma_data_ready_i, and increment deliver_cnt.
  - The mask is ignored on reads; the full block is always fetched.
  - On dequeue of word block_size_in_words_p-1, go to IDLE. The first mem_v_o may be asserted the cycle after the packet is accepted.
  - FIFO push and pop in the same cycle are allowed. The FIFO never overflows because of the credit rule.
- WRITE:
  - i = word_cnt. mem_v_o = dma_data_v_i & mask[i], with mem_w_o=1, mem_addr_o=base+i and mem_data_o=dma_data_i.
  - dma_data_yumi_o = dma_data_v_i & (~mask[i] | mem_yumi_i). Masked-off words are consumed without a memory write.
  - Each consumed word increments word_cnt. After word block_size_in_words_p-1 is consumed, go to IDLE.
- Counters wrap only via explicit clear on entry to IDLE. Their widths are sized so no arithmetic overflow occurs.
- Reset mid-operation: the transaction is abandoned immediately, the FIFO is flushed, and counters are cleared. Any mem_v_i arriving while outstanding==0 is dropped. The memory is reset together with this block.

Optional Feature:
- Macro: BSG_CACHE_DMA_TO_MEM_CHECK_EN.
- Defined: nonsynth checks active after reset. Each violation calls $error and $finish:
  - mem_v_i while outstanding==0;
  - mem_v_i while in WRITE or IDLE;
  - dma_pkt_v_i dropping while in IDLE before dma_pkt_yumi_o.
- Undefined: no checks; the synthesized logic is identical.

Test Plan:
- Read pkt addr=0x100, memory words 0x40..0x47 holding 0xA0..0xA7, ready held high: reads to addresses 0x40..0x47 in order, and dma_data_o delivers 0xA0..0xA7. Returns to IDLE after the 8th word.
- Write pkt addr=0x200, mask=8'b1010_0101, data 0xB0..0xB7: 8 words consumed, with exactly 4 memory writes at 0x80/0x82/0x85/0x87 carrying 0xB0/0xB2/0xB5/0xB7.
- Read with dma_data_ready_i low for 20 cycles, fifo_els_p=2: at most 2 reads are accepted before the stall. No data is lost and the order is preserved after ready rises.
- Memory stall with mem_yumi_i low for 5 cycles in mid-write: mem_v_o and address stay stable, dma_data_yumi_o stays 0, and the transaction completes normally afterwards.
- Unaligned read addr=0x10C: the first mem_addr_o is 0x40, not 0x43.
- Reset asserted after 3 fill words have been delivered: the next cycle shows IDLE with all valids low, and a following read pkt completes correctly.

Source files
------------

// File: rtl/bsg_cache_dma_to_mem.sv
// Bridges the bsg_cache DMA port to a word-wide request/response memory.
// Optional nonsynth protocol checks: define BSG_CACHE_DMA_TO_MEM_CHECK_EN.
module bsg_cache_dma_to_mem #(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int fifo_els_p            = 2,
  parameter int mem_addr_width_p      = addr_width_p
                                        - (((data_width_p/8) <= 1) ? 1 : $clog2(data_width_p/8))
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,

  input  logic [block_size_in_words_p+addr_width_p:0] dma_pkt_i,
  input  logic                                        dma_pkt_v_i,
  output logic                                        dma_pkt_yumi_o,

  output logic [data_width_p-1:0]                     dma_data_o,
  output logic                                        dma_data_v_o,
  input  logic                                        dma_data_ready_i,

  input  logic [data_width_p-1:0]                     dma_data_i,
  input  logic                                        dma_data_v_i,
  output logic                                        dma_data_yumi_o,

  output logic                                        mem_v_o,
  output logic                                        mem_w_o,
  output logic [mem_addr_width_p-1:0]                 mem_addr_o,
  output logic [data_width_p-1:0]                     mem_data_o,
  input  logic                                        mem_yumi_i,
  input  logic [data_width_p-1:0]                     mem_data_i,
  input  logic                                        mem_v_i
);

  localparam int lg_block_lp   = $clog2(block_size_in_words_p);
  localparam int cnt_width_lp  = lg_block_lp + 1;
  localparam int byte_off_lp   = addr_width_p - mem_addr_width_p;
  localparam int cred_width_lp = $clog2(fifo_els_p + 1);
  localparam int ptr_width_lp  = (fifo_els_p <= 1) ? 1 : $clog2(fifo_els_p);

  localparam logic [cnt_width_lp-1:0]  block_lp     = cnt_width_lp'(block_size_in_words_p);
  localparam logic [cnt_width_lp-1:0]  last_word_lp = cnt_width_lp'(block_size_in_words_p - 1);
  localparam logic [cred_width_lp:0]   fifo_els_lp  = (cred_width_lp + 1)'(fifo_els_p);
  localparam logic [ptr_width_lp-1:0]  last_ptr_lp  = ptr_width_lp'(fifo_els_p - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e state_r, state_n;

  // packet fields
  logic                             pkt_write;
  logic [block_size_in_words_p-1:0] pkt_mask;
  logic [addr_width_p-1:0]          pkt_addr;
  logic [addr_width_p-1:0]          pkt_blk_addr;
  logic [mem_addr_width_p-1:0]      pkt_base;

  assign pkt_write = dma_pkt_i[block_size_in_words_p+addr_width_p];
  assign pkt_mask  = dma_pkt_i[addr_width_p +: block_size_in_words_p];
  assign pkt_addr  = dma_pkt_i[addr_width_p-1:0];

  // drop the byte offset and the in-block word offset in one step
  assign pkt_blk_addr = (pkt_addr >> (byte_off_lp + lg_block_lp)) << lg_block_lp;
  assign pkt_base     = mem_addr_width_p'(pkt_blk_addr);

  logic [mem_addr_width_p-1:0]      base_r;
  logic [block_size_in_words_p-1:0] mask_r;
  logic [cnt_width_lp-1:0]          issue_cnt_r;
  logic [cnt_width_lp-1:0]          deliver_cnt_r;
  logic [cnt_width_lp-1:0]          word_cnt_r;
  logic [cred_width_lp-1:0]         outstanding_r;

  logic [data_width_p-1:0]  fifo_mem [fifo_els_p];
  logic [ptr_width_lp-1:0]  rd_ptr_r, wr_ptr_r;
  logic [cred_width_lp-1:0] fifo_cnt_r;

  logic                   fifo_empty;
  logic                   credit_ok;
  logic                   pkt_accept;
  logic                   rd_accept;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   wr_consume;
  logic                   txn_done;
  logic [lg_block_lp-1:0] issue_idx;
  logic [lg_block_lp-1:0] word_idx;

  assign fifo_empty = (fifo_cnt_r == '0);
  assign credit_ok  = (({1'b0, outstanding_r} + {1'b0, fifo_cnt_r}) < fifo_els_lp);
  assign issue_idx  = issue_cnt_r[lg_block_lp-1:0];
  assign word_idx   = word_cnt_r[lg_block_lp-1:0];

  assign dma_data_v_o = (state_r == READ) & ~fifo_empty;
  assign dma_data_o   = fifo_mem[rd_ptr_r];

  // late responses after an abandoned transaction are dropped here
  assign fifo_push  = mem_v_i & (outstanding_r != '0);
  assign fifo_pop   = dma_data_v_o & dma_data_ready_i;
  assign pkt_accept = dma_pkt_yumi_o;
  assign rd_accept  = (state_r == READ) & mem_v_o & mem_yumi_i;
  assign wr_consume = (state_r == WRITE) & dma_data_yumi_o;
  assign txn_done   = (fifo_pop & (deliver_cnt_r == last_word_lp))
                    | (wr_consume & (word_cnt_r == last_word_lp));

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n         = state_r;
    dma_pkt_yumi_o  = 1'b0;
    dma_data_yumi_o = 1'b0;
    mem_v_o         = 1'b0;
    mem_w_o         = 1'b0;
    mem_addr_o      = base_r + mem_addr_width_p'(issue_idx);
    mem_data_o      = dma_data_i;

    unique case (state_r)
      IDLE: begin
        dma_pkt_yumi_o = dma_pkt_v_i;
        if (dma_pkt_v_i) state_n = pkt_write ? WRITE : READ;
      end
      READ: begin
        mem_v_o = (issue_cnt_r < block_lp) & credit_ok;
        if (fifo_pop && (deliver_cnt_r == last_word_lp)) state_n = IDLE;
      end
      WRITE: begin
        mem_w_o         = 1'b1;
        mem_addr_o      = base_r + mem_addr_width_p'(word_idx);
        mem_v_o         = dma_data_v_i & mask_r[word_idx];
        dma_data_yumi_o = dma_data_v_i & (~mask_r[word_idx] | mem_yumi_i);
        if (dma_data_yumi_o && (word_cnt_r == last_word_lp)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (pkt_accept) begin
      base_r <= pkt_base;
      mask_r <= pkt_mask;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issue_cnt_r   <= '0;
      deliver_cnt_r <= '0;
      word_cnt_r    <= '0;
    end else if (txn_done) begin
      issue_cnt_r   <= '0;
      deliver_cnt_r <= '0;
      word_cnt_r    <= '0;
    end else begin
      if (rd_accept)  issue_cnt_r   <= issue_cnt_r + 1'b1;
      if (fifo_pop)   deliver_cnt_r <= deliver_cnt_r + 1'b1;
      if (wr_consume) word_cnt_r    <= word_cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      outstanding_r <= '0;
    end else begin
      unique case ({rd_accept, fifo_push})
        2'b10:   outstanding_r <= outstanding_r + 1'b1;
        2'b01:   outstanding_r <= outstanding_r - 1'b1;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_mem[wr_ptr_r] <= mem_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (fifo_push) wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
      if (fifo_pop)  rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
      unique case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 1'b1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 1'b1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

`ifdef BSG_CACHE_DMA_TO_MEM_CHECK_EN
  logic pkt_wait_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pkt_wait_r <= 1'b0;
    end else begin
      pkt_wait_r <= (state_r == IDLE) & dma_pkt_v_i & ~dma_pkt_yumi_o;
      if (mem_v_i && (outstanding_r == '0)) begin
        $error("bsg_cache_dma_to_mem: mem_v_i with nothing outstanding");
        $finish;
      end
      if (mem_v_i && (state_r != READ)) begin
        $error("bsg_cache_dma_to_mem: mem_v_i outside READ");
        $finish;
      end
      if (pkt_wait_r && !dma_pkt_v_i) begin
        $error("bsg_cache_dma_to_mem: dma_pkt_v_i dropped before yumi");
        $finish;
      end
    end
  end
`else
  // checks compiled out; datapath is unchanged
`endif

endmodule
